// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode: compacts up to IN_W valid
// fetch lanes per cycle into storage and presents up to OUT_W oldest entries to decode.
module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2,
    parameter int BW    = 172
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [IN_W*BW-1:0]       in_bundle,
    output logic                     in_ready,
    output logic [OUT_W*BW-1:0]      out_bundle,
    output logic [OUT_W-1:0]         out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] IN_W_C  = CW'(IN_W);
    localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [BW-1:0] mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic [CW-1:0] free_s;
    logic [CW-1:0] nin_s;
    logic [CW-1:0] nadd_s;
    logic [CW-1:0] ndeq_s;
    logic          enq_s;
    logic [IN_W-1:0] lane_vld_s;
    logic [PW-1:0] lane_off_s [IN_W];
    logic [PW-1:0] rd_idx_s [OUT_W];

    // Admission, lane compaction offsets and dequeue amount from registered state.
    always_comb begin
        free_s   = DEPTH_C - count_r;
        in_ready = (free_s >= IN_W_C) && !flush;
        nin_s    = '0;
        for (int i = 0; i < IN_W; i++) begin
            lane_vld_s[i] = in_bundle[i*BW + BW - 1];
            lane_off_s[i] = nin_s[PW-1:0];
            if (lane_vld_s[i]) begin
                nin_s = nin_s + ONE_C;
            end else begin
                nin_s = nin_s;
            end
        end
        enq_s  = in_ready && (nin_s != '0);
        nadd_s = enq_s ? nin_s : '0;
        if (out_ready && !flush) begin
            ndeq_s = (count_r < OUT_W_C) ? count_r : OUT_W_C;
        end else begin
            ndeq_s = '0;
        end
    end

    // Pointer and occupancy state; flush outranks any same-cycle enqueue/dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + ndeq_s[PW-1:0];
            tail_r  <= tail_r + nadd_s[PW-1:0];
            count_r <= count_r + nadd_s - ndeq_s;
        end
    end

    // Payload storage, deliberately unreset; valid lanes pack from tail upward.
    always_ff @(posedge clk) begin
        if (enq_s && !rst) begin
            for (int i = 0; i < IN_W; i++) begin
                if (lane_vld_s[i]) begin
                    mem_r[tail_r + lane_off_s[i]] <= in_bundle[i*BW +: BW];
                end
            end
        end
    end

    // Decode view: oldest entries from head, zeroed when the lane is not valid.
    always_comb begin
        out_valid  = '0;
        out_bundle = '0;
        for (int k = 0; k < OUT_W; k++) begin
            rd_idx_s[k]  = head_r + PW'(k);
            out_valid[k] = (count_r > CW'(k)) && !flush;
            if (out_valid[k]) begin
                out_bundle[k*BW +: BW] = mem_r[rd_idx_s[k]];
            end else begin
                out_bundle[k*BW +: BW] = '0;
            end
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    localparam int BW = 172;

    typedef struct {
        logic        fl;
        logic        ordy;
        logic        v0;
        logic [31:0] p0;
        logic        v1;
        logic [31:0] p1;
        logic [4:0]  cnt;
        logic [1:0]  ov;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ir;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [2*BW-1:0] in_bundle = '0;
    logic            in_ready;
    logic [2*BW-1:0] out_bundle;
    logic [1:0]      out_valid;
    logic            out_ready = 1'b0;
    logic [4:0]      count;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t va[$];
    vec_t vb[$];

    logic       mon_have = 1'b0;
    logic       mon_ir   = 1'b0;
    logic [4:0] mon_cnt  = 5'd0;

    fetch_queue #(.DEPTH(16), .IN_W(2), .OUT_W(2), .BW(BW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_bundle(in_bundle),
        .in_ready(in_ready), .out_bundle(out_bundle), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input logic v, input logic [31:0] pc);
        mk = {v, 107'd0, ~pc, pc};
    endfunction

    function automatic vec_t mkv(input logic fl, input logic ordy,
                                 input logic v0, input logic [31:0] p0,
                                 input logic v1, input logic [31:0] p1,
                                 input logic [4:0] cnt, input logic [1:0] ov,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic ir);
        vec_t v;
        v.fl = fl; v.ordy = ordy; v.v0 = v0; v.p0 = p0; v.v1 = v1; v.p1 = p1;
        v.cnt = cnt; v.ov = ov; v.e0 = e0; v.e1 = e1; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_bundle = '0;
    endtask

    task automatic check_state(input string tag, input vec_t v);
        logic [BW-1:0] x0;
        logic [BW-1:0] x1;
        x0 = v.ov[0] ? mk(1'b1, v.e0) : '0;
        x1 = v.ov[1] ? mk(1'b1, v.e1) : '0;
        chk({tag, " count"}, BW'(count), BW'(v.cnt));
        chk({tag, " out_valid"}, BW'(out_valid), BW'(v.ov));
        chk({tag, " in_ready"}, BW'(in_ready), BW'(v.ir));
        chk({tag, " lane0"}, out_bundle[BW-1:0], x0);
        chk({tag, " lane1"}, out_bundle[2*BW-1:BW], x1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        flush     = v.fl;
        out_ready = v.ordy;
        in_bundle = {mk(v.v1, v.p1), mk(v.v0, v.p0)};
        @(posedge clk);
        #1;
        idle();
        #1;
        check_state(tag, v);
    endtask

    // Invariant monitor: occupancy bound and no growth while in_ready was low.
    always @(negedge clk) begin
        if (mon_have) begin
            n_tests++;
            if (!mon_ir && (count > mon_cnt)) begin
                n_fail++;
                $display("FAIL accept_not_ready: count %0d after %0d, required no growth", count, mon_cnt);
            end
        end
        n_tests++;
        if (count > 5'd16) begin
            n_fail++;
            $display("FAIL count_bound: count %0d, required <= 16", count);
        end
        mon_ir   = in_ready;
        mon_cnt  = count;
        mon_have = 1'b1;
    end

    initial begin
        // Table A: basic pair, sparse lane, simultaneous traffic, fill and drain.
        va.push_back(mkv(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004, 5'd2, 2'b11, 32'h8000_0000, 32'h8000_0004, 1'b1));
        va.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));
        va.push_back(mkv(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1000, 5'd1, 2'b01, 32'h1000, 32'h0, 1'b1));
        va.push_back(mkv(1'b0, 1'b1, 1'b1, 32'h2000, 1'b1, 32'h2004, 5'd2, 2'b11, 32'h2000, 32'h2004, 1'b1));
        va.push_back(mkv(1'b0, 1'b0, 1'b1, 32'h2008, 1'b0, 32'h0BAD, 5'd3, 2'b11, 32'h2000, 32'h2004, 1'b1));
        va.push_back(mkv(1'b0, 1'b1, 1'b1, 32'h200C, 1'b1, 32'h2010, 5'd3, 2'b11, 32'h2008, 32'h200C, 1'b1));
        va.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 2'b01, 32'h2010, 32'h0, 1'b1));
        va.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));
        for (int i = 0; i < 8; i++) begin
            va.push_back(mkv(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(8*i), 1'b1, 32'h3004 + 32'(8*i),
                             5'(2*i+2), 2'b11, 32'h3000, 32'h3004, (2*i+2) <= 14));
        end
        va.push_back(mkv(1'b0, 1'b0, 1'b1, 32'h4000, 1'b1, 32'h4004, 5'd16, 2'b11, 32'h3000, 32'h3004, 1'b0));
        for (int j = 0; j < 8; j++) begin
            va.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'(14-2*j),
                             (14-2*j) > 0 ? 2'b11 : 2'b00,
                             32'h3000 + 32'(8*(j+1)), 32'h3004 + 32'(8*(j+1)), 1'b1));
        end

        // Table B: walk pointers to 15, wrap a pair, hit count 15, drain to 5.
        for (int i = 0; i < 15; i++) begin
            vb.push_back(mkv(1'b0, 1'b1, 1'b1, 32'h5000 + 32'(4*i), 1'b0, 32'h0,
                             5'd1, 2'b01, 32'h5000 + 32'(4*i), 32'h0, 1'b1));
        end
        vb.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));
        vb.push_back(mkv(1'b0, 1'b0, 1'b1, 32'hA000, 1'b1, 32'hB000, 5'd2, 2'b11, 32'hA000, 32'hB000, 1'b1));
        for (int k = 0; k < 6; k++) begin
            vb.push_back(mkv(1'b0, 1'b0, 1'b1, 32'hC000 + 32'(8*k), 1'b1, 32'hC004 + 32'(8*k),
                             5'(4+2*k), 2'b11, 32'hA000, 32'hB000, 1'b1));
        end
        vb.push_back(mkv(1'b0, 1'b0, 1'b1, 32'hD000, 1'b0, 32'h0, 5'd15, 2'b11, 32'hA000, 32'hB000, 1'b0));
        vb.push_back(mkv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hD004, 5'd15, 2'b11, 32'hA000, 32'hB000, 1'b0));
        for (int d = 1; d <= 5; d++) begin
            vb.push_back(mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'(15-2*d), 2'b11,
                             32'hC000 + 32'(8*(d-1)), 32'hC004 + 32'(8*(d-1)), 1'b1));
        end

        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_state("reset", mkv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));

        for (int i = 0; i < va.size(); i++) begin
            run_vec($sformatf("A%0d", i), va[i]);
        end

        // Asynchronous reset between clock edges with entries present.
        run_vec("R0", mkv(1'b0, 1'b0, 1'b1, 32'h6000, 1'b1, 32'h6004, 5'd2, 2'b11, 32'h6000, 32'h6004, 1'b1));
        run_vec("R1", mkv(1'b0, 1'b0, 1'b1, 32'h6008, 1'b0, 32'h0, 5'd3, 2'b11, 32'h6000, 32'h6004, 1'b1));
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst count", BW'(count), BW'(5'd0));
        chk("async_rst out_valid", BW'(out_valid), BW'(2'b00));
        chk("async_rst lane0", out_bundle[BW-1:0], '0);
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", BW'(in_ready), BW'(1'b1));

        for (int i = 0; i < vb.size(); i++) begin
            run_vec($sformatf("B%0d", i), vb[i]);
        end

        // Flush at count 5 with a valid input group and out_ready asserted.
        flush     = 1'b1;
        out_ready = 1'b1;
        in_bundle = {mk(1'b1, 32'hE004), mk(1'b1, 32'hE000)};
        #1;
        chk("flush out_valid", BW'(out_valid), BW'(2'b00));
        chk("flush in_ready", BW'(in_ready), BW'(1'b0));
        chk("flush lane0", out_bundle[BW-1:0], '0);
        chk("flush count_hold", BW'(count), BW'(5'd5));
        @(posedge clk);
        #1;
        idle();
        #1;
        check_state("post_flush", mkv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));
        run_vec("F1", mkv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000, 5'd1, 2'b01, 32'hF000, 32'h0, 1'b1));
        run_vec("F2", mkv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
